// File: rtl/mux_operand_sequencer.sv
// Operand stager for the 8-bit 4-lane select mux: gathers four stream bytes into lanes a..d,
// then sweeps o_sel 0 -> 1. Optional MUX_SEQ_FRAME_CNT_EN adds an 8-bit completed-frame counter.
module mux_operand_sequencer #(
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b,
  output logic [DATA_W-1:0] o_c,
  output logic [DATA_W-1:0] o_d,
  output logic              o_sel,
  output logic              o_out_valid
`ifdef MUX_SEQ_FRAME_CNT_EN
  ,
  output logic [7:0]        o_frame_cnt
`endif
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SWEEP0 = 2'd1,
    SWEEP1 = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       idx;
  logic [CNT_W-1:0] hold_cnt;
  logic             take;

  assign take = i_valid && o_ready;

  // NOTE: every register here updates with <= so all of them see the same pre-edge values;
  // blocking assignments would let later statements observe half-updated state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= FILL;
      idx         <= 2'd0;
      hold_cnt    <= '0;
      o_a         <= '0;
      o_b         <= '0;
      o_c         <= '0;
      o_d         <= '0;
      o_sel       <= 1'b0;
      o_out_valid <= 1'b0;
      o_ready     <= 1'b0;
`ifdef MUX_SEQ_FRAME_CNT_EN
      o_frame_cnt <= 8'd0;
`endif
    end else if (i_flush) begin
      // Abort wins over everything, including a byte offered on the same edge.
      state       <= FILL;
      idx         <= 2'd0;
      hold_cnt    <= '0;
      o_a         <= '0;
      o_b         <= '0;
      o_c         <= '0;
      o_d         <= '0;
      o_sel       <= 1'b0;
      o_out_valid <= 1'b0;
      o_ready     <= 1'b1;
    end else begin
      case (state)
        FILL: begin
          o_ready <= 1'b1;
          if (take) begin
            case (idx)
              2'd0: o_a <= i_data;
              2'd1: o_b <= i_data;
              2'd2: o_c <= i_data;
              2'd3: o_d <= i_data;
            endcase
            if (idx == 2'd3) begin
              idx         <= 2'd0;
              hold_cnt    <= '0;
              o_ready     <= 1'b0;
              o_out_valid <= 1'b1;
              o_sel       <= 1'b0;
              state       <= SWEEP0;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end

        SWEEP0: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            o_sel    <= 1'b1;
            state    <= SWEEP1;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end

        SWEEP1: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt    <= '0;
            o_sel       <= 1'b0;
            o_out_valid <= 1'b0;
            o_ready     <= 1'b1;
            state       <= FILL;
`ifdef MUX_SEQ_FRAME_CNT_EN
            o_frame_cnt <= o_frame_cnt + 8'd1;
`endif
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end

        default: begin
          hold_cnt <= '0;
          state    <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_operand_sequencer.sv
// Drives two sequencers (HOLD_CYCLES=1 and 3) from one stream and compares each against
// a cycle-level model built from byte counts and a sweep countdown.
module tb_mux_operand_sequencer;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] data  = 8'h00;

  always #5 clk = ~clk;

  wire [7:0] y_a [2];
  wire [7:0] y_b [2];
  wire [7:0] y_c [2];
  wire [7:0] y_d [2];
  wire       y_sel [2];
  wire       y_vld [2];
  wire       y_rdy [2];
`ifdef MUX_SEQ_FRAME_CNT_EN
  wire [7:0] y_cnt [2];
`endif

  mux_operand_sequencer #(.DATA_W(8), .HOLD_CYCLES(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .o_ready(y_rdy[0]),
    .i_flush(flush), .o_a(y_a[0]), .o_b(y_b[0]), .o_c(y_c[0]), .o_d(y_d[0]),
    .o_sel(y_sel[0]), .o_out_valid(y_vld[0])
`ifdef MUX_SEQ_FRAME_CNT_EN
    , .o_frame_cnt(y_cnt[0])
`endif
  );

  mux_operand_sequencer #(.DATA_W(8), .HOLD_CYCLES(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .o_ready(y_rdy[1]),
    .i_flush(flush), .o_a(y_a[1]), .o_b(y_b[1]), .o_c(y_c[1]), .o_d(y_d[1]),
    .o_sel(y_sel[1]), .o_out_valid(y_vld[1])
`ifdef MUX_SEQ_FRAME_CNT_EN
    , .o_frame_cnt(y_cnt[1])
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: lanes, bytes gathered so far, and cycles left in the sweep (2*H down to 0).
  int         hold_of [2] = '{1, 3};
  logic [7:0] m_lane  [2][4];
  int         m_n     [2];
  int         m_busy  [2];
  int         m_acc   [2];
  int         m_frames[2];
  bit         m_ready [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0;
      m_frames[k] = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int j = 0; j < 4; j++) m_lane[k][j] = 8'h00;
        m_n[k] = 0;
        m_busy[k] = 0;
        m_ready[k] = 1'b0;
        m_frames[k] = 0;
      end else if (flush) begin
        for (int j = 0; j < 4; j++) m_lane[k][j] = 8'h00;
        m_n[k] = 0;
        m_busy[k] = 0;
        m_ready[k] = 1'b1;
      end else if (m_busy[k] > 0) begin
        m_busy[k] = m_busy[k] - 1;
        if (m_busy[k] == 0) begin
          m_ready[k] = 1'b1;
          m_frames[k] = (m_frames[k] + 1) % 256;
        end
      end else begin
        automatic bit was_ready = m_ready[k];
        m_ready[k] = 1'b1;
        if (valid && was_ready) begin
          m_lane[k][m_n[k]] = data;
          m_acc[k] = m_acc[k] + 1;
          m_n[k] = m_n[k] + 1;
          if (m_n[k] == 4) begin
            m_n[k] = 0;
            m_busy[k] = 2 * hold_of[k];
            m_ready[k] = 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("d%0d_a", k),   32'(y_a[k]), 32'(m_lane[k][0]));
        check($sformatf("d%0d_b", k),   32'(y_b[k]), 32'(m_lane[k][1]));
        check($sformatf("d%0d_c", k),   32'(y_c[k]), 32'(m_lane[k][2]));
        check($sformatf("d%0d_d", k),   32'(y_d[k]), 32'(m_lane[k][3]));
        check($sformatf("d%0d_vld", k), 32'(y_vld[k]), 32'(m_busy[k] > 0));
        check($sformatf("d%0d_sel", k), 32'(y_sel[k]),
              32'(m_busy[k] > 0 && m_busy[k] <= hold_of[k]));
        check($sformatf("d%0d_rdy", k), 32'(y_rdy[k]), 32'(m_ready[k]));
`ifdef MUX_SEQ_FRAME_CNT_EN
        check($sformatf("d%0d_cnt", k), 32'(y_cnt[k]), 32'(m_frames[k]));
`endif
      end
    end
  end

  // Offer n bytes (first, first+step, ...) until DUT k has accepted all of them.
  // Returns at the falling edge right after the last accepting edge, with valid dropped.
  task automatic feed(input int k, input int n, input logic [7:0] first,
                      input logic [7:0] step, output int stalls);
    int base;
    int cyc;
    int idx;
    base = m_acc[k];
    cyc = 0;
    stalls = 0;
    forever begin
      @(negedge clk);
      idx = m_acc[k] - base;
      if (idx >= n) break;
      if (!y_rdy[k]) stalls++;
      cyc++;
      if (cyc > 200) begin
        check("feed_timeout", 32'(idx), 32'(n));
        break;
      end
      flush = 1'b0;
      valid = 1'b1;
      data  = first + 8'(idx) * step;
    end
    valid = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    valid = 1'b0;
    flush = 1'b0;
    while (m_busy[0] != 0 || m_busy[1] != 0) begin
      @(negedge clk);
      cyc++;
      if (cyc > 50) begin
        check("idle_timeout", 32'(m_busy[0] + m_busy[1]), 32'd0);
        break;
      end
    end
  endtask

  task automatic align();
    wait_idle();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  int stalls;
`ifdef MUX_SEQ_FRAME_CNT_EN
  logic [7:0] cnt_before;
`endif

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      check("rst_rdy", 32'(y_rdy[k]), 32'd0);
      check("rst_a", 32'(y_a[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rdy_after_release", 32'(y_rdy[0]), 32'd1);

    // Back-to-back frame, H=1 timing.
    feed(0, 4, 8'h11, 8'h11, stalls);
    check("t1_vld_n", 32'(y_vld[0]), 32'd1);
    check("t1_sel_n", 32'(y_sel[0]), 32'd0);
    check("t1_rdy_n", 32'(y_rdy[0]), 32'd0);
    check("t1_lanes", {y_a[0], y_b[0], y_c[0], y_d[0]}, 32'h11223344);
    @(negedge clk);
    check("t1_vld_n1", 32'(y_vld[0]), 32'd1);
    check("t1_sel_n1", 32'(y_sel[0]), 32'd1);
    @(negedge clk);
    check("t1_vld_n2", 32'(y_vld[0]), 32'd0);
    check("t1_sel_n2", 32'(y_sel[0]), 32'd0);
    check("t1_rdy_n2", 32'(y_rdy[0]), 32'd1);

    // H=3 with valid held: second group stalls for the six sweep cycles.
    align();
    feed(1, 8, 8'h31, 8'h01, stalls);
    check("t2_stalls", 32'(stalls), 32'd6);
    check("t2_lanes", {y_a[1], y_b[1], y_c[1], y_d[1]}, 32'h35363738);
    check("t2_vld", 32'(y_vld[1]), 32'd1);

    // Partial frame aborted by flush with a simultaneous byte.
    align();
    feed(0, 2, 8'hC1, 8'h01, stalls);
    check("t3_partial_a", 32'(y_a[0]), 32'hC1);
    check("t3_partial_b", 32'(y_b[0]), 32'hC2);
    flush = 1'b1;
    valid = 1'b1;
    data  = 8'hEE;
    @(negedge clk);
    flush = 1'b0;
    valid = 1'b0;
    check("t3_flush_lanes", {y_a[0], y_b[0], y_c[0], y_d[0]}, 32'h0);
    check("t3_flush_vld", 32'(y_vld[0]), 32'd0);
    feed(0, 4, 8'hA1, 8'h01, stalls);
    check("t3_new_lanes", {y_a[0], y_b[0], y_c[0], y_d[0]}, 32'hA1A2A3A4);

    // Flush during SWEEP1 on the H=1 unit.
    align();
    feed(0, 4, 8'h51, 8'h02, stalls);
    @(negedge clk);
    check("t4_in_sweep1", 32'(y_sel[0]), 32'd1);
`ifdef MUX_SEQ_FRAME_CNT_EN
    cnt_before = y_cnt[0];
`endif
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t4_vld", 32'(y_vld[0]), 32'd0);
    check("t4_sel", 32'(y_sel[0]), 32'd0);
    check("t4_rdy", 32'(y_rdy[0]), 32'd1);
    check("t4_lanes", {y_a[0], y_b[0], y_c[0], y_d[0]}, 32'h0);
`ifdef MUX_SEQ_FRAME_CNT_EN
    check("t4_cnt", 32'(y_cnt[0]), 32'(cnt_before));
`endif

    // Asynchronous reset in the middle of SWEEP0.
    align();
    feed(0, 4, 8'h71, 8'h03, stalls);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("t5_a", 32'(y_a[k]), 32'd0);
      check("t5_b", 32'(y_b[k]), 32'd0);
      check("t5_c", 32'(y_c[k]), 32'd0);
      check("t5_d", 32'(y_d[k]), 32'd0);
      check("t5_sel", 32'(y_sel[k]), 32'd0);
      check("t5_vld", 32'(y_vld[k]), 32'd0);
      check("t5_rdy", 32'(y_rdy[k]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("t5_rdy_before_edge", 32'(y_rdy[0]), 32'd0);
    @(posedge clk);
    #1;
    check("t5_rdy_after_edge", 32'(y_rdy[0]), 32'd1);
    check("t5_rdy_after_edge3", 32'(y_rdy[1]), 32'd1);

    // 257 frames on the H=1 unit; counter wraps to 1.
    for (int f = 0; f < 257; f++) begin
      feed(0, 4, 8'($urandom), 8'($urandom_range(1, 255)), stalls);
    end
    wait_idle();
    @(negedge clk);
`ifdef MUX_SEQ_FRAME_CNT_EN
    check("t6_cnt_wrap", 32'(y_cnt[0]), 32'd1);
`endif
    check("t6_idle_rdy", 32'(y_rdy[0]), 32'd1);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      valid = ($urandom_range(0, 9) < 7);
      data  = 8'($urandom);
      flush = ($urandom_range(0, 31) == 0);
    end
    @(negedge clk);
    valid = 1'b0;
    flush = 1'b0;
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
